// File: rtl/inst_queue_pkg.sv
// Shared types and sizing for the in-order instruction buffer between decode and dispatch.
// Holds the decoded instruction layout and the default queue depth.
package inst_queue_pkg;

    localparam int IQ_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  dest_reg;
        logic [3:0]  fu_op;
    } DECODED_PACK;

endpackage

// File: rtl/inst_queue.sv
// In-order circular instruction buffer; absorbs dispatch stalls so decode keeps running.
// All outputs derive from registered pointers/count only, so stall never reaches in_ready.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  DECODED_PACK                in_pack,
    output logic                       in_ready,
    output logic                       out_valid,
    output DECODED_PACK                out_pack,
    input  logic                       dispatch_stall,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    DECODED_PACK        storage [DEPTH];
    logic [PTR_W-1:0]   head_reg, tail_reg;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               push, pop;

    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_pack  = empty ? '0 : storage[head_reg];
    assign count     = count_reg;

    // Flush discards any same-cycle transfer, so it gates both handshakes.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && !dispatch_stall && !flush;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // Payload storage is never reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[tail_reg] <= in_pack;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            assert (count_reg <= CNT_W'(DEPTH));
            assert (!(pop && empty));
            assert (!full || (head_reg == tail_reg));
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, fill/refuse, in-order drain, streaming, flush, async reset.
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    DECODED_PACK in_pack;
    logic        in_ready;
    logic        out_valid;
    DECODED_PACK out_pack;
    logic        dispatch_stall;
    logic        flush;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int total = 0;
    int bad   = 0;

    inst_queue #(.DEPTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_pack        (in_pack),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_pack       (out_pack),
        .dispatch_stall (dispatch_stall),
        .flush          (flush),
        .count          (count),
        .full           (full),
        .empty          (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic DECODED_PACK mk(input logic [31:0] pc);
        DECODED_PACK p;
        p.pc       = pc;
        p.inst     = pc ^ 32'hDEAD_BEEF;
        p.dest_reg = pc[6:2];
        p.fu_op    = pc[5:2];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        in_valid       = 1'b0;
        in_pack        = '0;
        dispatch_stall = 1'b1;
        flush          = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_pack",  out_pack,  0);
        chk("rst_ready", in_ready,  1);
        chk("rst_full",  full,      0);
        chk("rst_empty", empty,     1);
        chk("rst_count", count,     0);
        reset = 1'b1;

        // Push A: no bypass, appears after the edge
        in_valid = 1'b1;
        in_pack  = mk(32'h0);
        chk("nobypass", out_valid, 0);
        step();
        chk("a_valid", out_valid,   1);
        chk("a_pc",    out_pack.pc, 32'h0);
        chk("a_pack",  out_pack,    mk(32'h0));
        chk("a_count", count,       1);

        // Fill to 8 while stalled
        for (int i = 1; i < 8; i++) begin
            in_pack = mk(32'(4 * i));
            step();
        end
        chk("fill_full",  full,     1);
        chk("fill_ready", in_ready, 0);
        chk("fill_count", count,    8);

        // 9th push refused
        in_pack = mk(32'h20);
        step();
        chk("refuse_cnt", count,       8);
        chk("refuse_hd",  out_pack.pc, 32'h0);

        // Release stall holding 0x20: first pop while full refuses the push
        dispatch_stall = 1'b0;
        chk("drain_0", out_pack.pc, 32'h0);
        step();
        chk("pop1_cnt", count, 7);
        chk("drain_4", out_pack.pc, 32'h4);
        step();
        chk("acc20_cnt", count, 7);
        in_valid = 1'b0;
        for (int i = 2; i < 9; i++) begin
            chk("drain_pc", out_pack.pc, 32'(4 * i));
            step();
        end
        chk("drain_empty", empty, 1);

        // Streaming push+pop for 20 instructions
        in_valid = 1'b1;
        in_pack  = mk(32'h100);
        step();
        chk("strm_cnt0", count, 1);
        for (int i = 1; i < 20; i++) begin
            in_pack = mk(32'h100 + 32'(4 * i));
            chk("strm_pc", out_pack.pc, 32'h100 + 32'(4 * (i - 1)));
            step();
            chk("strm_cnt", count, 1);
        end
        in_valid = 1'b0;
        chk("strm_last", out_pack.pc, 32'h14C);
        step();
        chk("strm_empty", empty, 1);

        // Flush with count=5, concurrent push of 0x40 and a pop
        dispatch_stall = 1'b1;
        in_valid       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_pack = mk(32'h200 + 32'(4 * i));
            step();
        end
        chk("pre_fl_cnt", count, 5);
        in_pack        = mk(32'h40);
        flush          = 1'b1;
        dispatch_stall = 1'b0;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_count", count,     0);
        chk("fl_empty", empty,     1);
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready,  1);
        chk("fl_pack",  out_pack,  0);
        step();
        chk("fl_no40", out_valid, 0);
        in_valid = 1'b1;
        in_pack  = mk(32'h44);
        dispatch_stall = 1'b1;
        step();
        in_valid = 1'b0;
        chk("fl_after", out_pack.pc, 32'h44);
        chk("fl_acnt",  count,       1);

        // Async reset with count=3, between edges
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_pack = mk(32'h300 + 32'(4 * i));
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_cnt", count, 3);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_count", count,     0);
        chk("ar_full",  full,      0);
        chk("ar_ready", in_ready,  1);
        chk("ar_empty", empty,     1);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_pack  = mk(32'h80);
        #1;
        chk("ar_nobyp", out_valid, 0);
        step();
        in_valid = 1'b0;
        chk("ar_pc",  out_pack.pc, 32'h80);
        chk("ar_cnt", count,       1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
